// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_pkg
// Brief   : Shared widths and the write-back request record.
// Revision: 1.0
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_if
// Brief   : Execute/memory-side result buses, decode hazard query, regfile write port.
// Revision: 1.0
// ============================================================================
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_data_i;
    logic                  ll_valid_i;
    logic                  ll_ready_o;
    logic [REG_ADDR_W-1:0] ll_rd_i;
    logic [XLEN-1:0]       ll_data_i;
    logic                  issue_valid_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;
    logic [REG_ADDR_W-1:0] rs1_id_i;
    logic [REG_ADDR_W-1:0] rs2_id_i;
    logic                  hazard_o;
    logic                  alu_stall_o;
    logic                  w_en;
    logic [REG_ADDR_W-1:0] rd_id_o;
    logic [XLEN-1:0]       rd_write_data_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ll_valid_i, ll_rd_i, ll_data_i,
        output issue_valid_i, issue_rd_i, rs1_id_i, rs2_id_i,
        input  ll_ready_o, hazard_o, alu_stall_o,
        input  w_en, rd_id_o, rd_write_data_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ll_valid_i, ll_rd_i, ll_data_i,
        input  issue_valid_i, issue_rd_i, rs1_id_i, rs2_id_i,
        output ll_ready_o, hazard_o, alu_stall_o,
        output w_en, rd_id_o, rd_write_data_o
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Synchronous FIFO of write-back requests for long-latency results.
// Revision: 1.0
// ============================================================================
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    i_push,
    input  wire wb_req_t i_wdata,
    input  wire logic    i_pop,
    output wb_req_t      o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    wb_req_t          r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Merges ALU and long-latency results into one registered regfile
//           write stream; tracks pending long-latency writes for RAW stalls.
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int c_SCW = $clog2(STARVE_MAX) + 1;

    wb_req_t               w_head;
    wb_req_t               w_sel;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_valid;
    logic                  w_stall;
    logic [NUM_REGS-1:0]   w_pending_nxt;
    logic [NUM_REGS-1:0]   r_pending;
    logic [c_SCW-1:0]      r_starve_cnt;
    logic                  r_w_en;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;

    assign w_push = bus.ll_valid_i && !w_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({bus.ll_rd_i, bus.ll_data_i}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_stall = (r_starve_cnt == c_SCW'(STARVE_MAX - 1)) && !w_empty;

    always_comb begin
        w_pop       = 1'b0;
        w_sel_valid = 1'b0;
        w_sel       = {bus.alu_rd_i, bus.alu_data_i};
        if (w_stall) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel       = w_head;
        end else if (bus.alu_valid_i) begin
            w_sel_valid = 1'b1;
        end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel       = w_head;
        end
    end

    // The stall forces a pop, so the counter never passes STARVE_MAX-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= r_starve_cnt + c_SCW'(1);
        end
    end

    // Clear first so a same-cycle issue to the popped register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop && (w_head.rd != '0)) begin
            w_pending_nxt[w_head.rd] = 1'b0;
        end
        if (bus.issue_valid_i && (bus.issue_rd_i != '0)) begin
            w_pending_nxt[bus.issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_w_en <= w_sel_valid && (w_sel.rd != '0);
            if (w_sel_valid) begin
                r_rd   <= w_sel.rd;
                r_data <= w_sel.data;
            end
        end
    end

    assign bus.ll_ready_o      = !w_full;
    assign bus.alu_stall_o     = w_stall;
    assign bus.hazard_o        = r_pending[bus.rs1_id_i] | r_pending[bus.rs2_id_i];
    assign bus.w_en            = r_w_en;
    assign bus.rd_id_o         = r_rd;
    assign bus.rd_write_data_o = r_data;

endmodule
`default_nettype wire
